// File: rtl/lsu_master.sv
// Load/store unit, initiator side of the data-memory interface.
// Steers store bytes into lanes, aligns/extends load data, flags misalignment and response timeout.
module lsu_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic              wen_q, wen_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]        mem_wmask_q, mem_wmask_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              f3_ok, misal;
  logic [7:0]        lane_mask;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] rd_shift, ld_data;

  // Request legality and store lane steering, evaluated on the incoming request
  always_comb begin
    unique case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = ~req_wen;
      default:                f3_ok = 1'b0;
    endcase
    misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
            ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    unique case (req_funct3[1:0])
      2'b00: begin
        lane_mask  = 8'b0000_0001 << req_addr[1:0];
        lane_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane_mask  = 8'b0000_0011 << req_addr[1:0];
        lane_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        lane_mask  = 8'h0F;
        lane_wdata = req_wdata;
      end
    endcase
    if (!req_wen) begin
      lane_mask  = '0;
      lane_wdata = '0;
    end
  end

  // Load alignment on the raw response word
  always_comb begin
    rd_shift = mem_rsp_rdata >> {off_q, 3'b000};
    unique case (funct3_q)
      3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  ld_data = {24'd0, rd_shift[7:0]};
      3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  ld_data = {16'd0, rd_shift[15:0]};
      default: ld_data = rd_shift;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wen_d       = wen_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    mem_valid_d = mem_valid_q;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wen_d    = req_wen;
          funct3_d = req_funct3;
          off_d    = req_addr[1:0];
          if (!f3_ok || misal) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = S_REQ;
            mem_valid_d = 1'b1;
            mem_wen_d   = req_wen;
            mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = lane_wdata;
            mem_wmask_d = lane_mask;
          end
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          cnt_d       = '0;
          // A response coincident with the handshake skips WAIT entirely
          if (mem_rsp_valid) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = wen_q ? '0 : ld_data;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = wen_q ? '0 : ld_data;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wen_q       <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wen_q       <= wen_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      mem_valid_q <= mem_valid_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign mem_valid = mem_valid_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_lsu_master.sv
// Directed bench for lsu_master: lane steering, load extension, errors, stalls, timeout and reset abort.
module tb_lsu_master;

  localparam int unsigned TO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_valid, mem_ready, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  int n_chk = 0;
  int n_bad = 0;
  int hs_cnt = 0;

  lsu_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_valid && mem_ready) hs_cnt <= hs_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic chk_mem(input string tag, input logic wen, input logic [31:0] ea,
                         input logic [31:0] ewd, input logic [7:0] em);
    chk({tag, "/mem_valid"}, 32'(mem_valid), 32'd1);
    chk({tag, "/mem_wen"},   32'(mem_wen),   32'(wen));
    chk({tag, "/mem_addr"},  mem_addr,       ea);
    chk({tag, "/mem_wmask"}, 32'(mem_wmask), 32'(em));
    if (wen) chk({tag, "/mem_wdata"}, mem_wdata, ewd);
  endtask

  // rsp_dly < 0: response coincides with the handshake
  task automatic do_op(input string tag, input logic wen, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int rdy_dly, input int rsp_dly, input logic [31:0] raw,
                       input logic [31:0] ea, input logic [31:0] ewd, input logic [7:0] em,
                       input logic [31:0] erd);
    int hs0;
    @(negedge clk);
    chk({tag, "/req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < rdy_dly; i++) begin
      chk_mem({tag, "/stall"}, wen, ea, ewd, em);
      @(negedge clk);
    end
    chk_mem(tag, wen, ea, ewd, em);
    hs0 = hs_cnt;
    mem_ready = 1'b1;
    if (rsp_dly < 0) begin
      mem_rsp_valid = 1'b1; mem_rsp_rdata = raw;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    chk({tag, "/mem_valid_drop"}, 32'(mem_valid), 32'd0);
    if (rsp_dly >= 0) begin
      chk({tag, "/early_rsp"}, 32'(rsp_valid), 32'd0);
      for (int i = 0; i < rsp_dly; i++) @(negedge clk);
      mem_rsp_valid = 1'b1; mem_rsp_rdata = raw;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
    end
    chk({tag, "/rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "/rsp_err"},   32'(rsp_err),   32'd0);
    chk({tag, "/rsp_rdata"}, rsp_rdata,      erd);
    chk({tag, "/handshakes"}, 32'(hs_cnt - hs0), 32'd1);
    @(negedge clk);
    chk({tag, "/rsp_pulse"}, 32'(rsp_valid), 32'd0);
    chk({tag, "/ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int k;
    bit seen_mv;
    rst = 1'b1;
    req_valid = 0; req_wen = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    mem_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;
    repeat (3) @(negedge clk);
    chk("rst/mem_valid", 32'(mem_valid), 32'd0);
    chk("rst/rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst/mem_addr",  mem_addr,       32'd0);
    chk("rst/mem_wmask", 32'(mem_wmask), 32'd0);
    rst = 1'b0;

    // Loads at minimum latency with byte/half extension
    do_op("lbu", 0, 3'b100, 32'h8000_0003, 0, 0, 0, 32'hAB12_3456, 32'h8000_0000, 0, 8'h00, 32'h0000_00AB);
    do_op("lb",  0, 3'b000, 32'h8000_0003, 0, 0, 0, 32'hAB12_3456, 32'h8000_0000, 0, 8'h00, 32'hFFFF_FFAB);
    do_op("lh",  0, 3'b001, 32'h8000_0006, 0, 0, 1, 32'h8001_7F00, 32'h8000_0004, 0, 8'h00, 32'hFFFF_8001);
    do_op("lhu", 0, 3'b101, 32'h8000_0006, 0, 0, 2, 32'h8001_7F00, 32'h8000_0004, 0, 8'h00, 32'h0000_8001);
    do_op("lh0", 0, 3'b001, 32'h0000_0100, 0, 1, 0, 32'h1234_7FFE, 32'h0000_0100, 0, 8'h00, 32'h0000_7FFE);
    // Stores
    do_op("sh",  1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 0, 0, 32'hDEAD_DEAD, 32'h8000_0000, 32'hBEEF_BEEF, 8'h0C, 0);
    do_op("sb",  1, 3'b000, 32'h0000_0011, 32'h1234_565A, 0, 0, 0, 32'h0000_0010, 32'h5A5A_5A5A, 8'h02, 0);
    do_op("sw_stall", 1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 5, 1, 0, 32'h0000_0020, 32'hCAFE_F00D, 8'h0F, 0);
    // Response arriving with the handshake
    do_op("lw_same", 0, 3'b010, 32'h0000_0040, 0, 2, -1, 32'h1357_9BDF, 32'h0000_0040, 0, 8'h00, 32'h1357_9BDF);

    // Misaligned word and illegal store funct3: error without any memory request
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_wen    = (t == 1);
      req_funct3 = (t == 0) ? 3'b010 : 3'b100;
      req_addr   = (t == 0) ? 32'h8000_0001 : 32'h8000_0000;
      @(negedge clk);
      req_valid = 1'b0;
      seen_mv = 1'b0;
      k = 0;
      while (!rsp_valid && k < 2) begin
        seen_mv |= mem_valid;
        @(negedge clk);
        k++;
      end
      seen_mv |= mem_valid;
      chk("err/rsp_valid", 32'(rsp_valid), 32'd1);
      chk("err/rsp_err",   32'(rsp_err),   32'd1);
      chk("err/rsp_rdata", rsp_rdata,      32'd0);
      chk("err/mem_valid", 32'(seen_mv),   32'd0);
      @(negedge clk);
      chk("err/rsp_pulse", 32'(rsp_valid), 32'd0);
    end

    // Timeout: no response after the handshake
    @(negedge clk);
    req_valid = 1'b1; req_wen = 0; req_funct3 = 3'b010; req_addr = 32'h0000_0080;
    @(negedge clk);
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    k = 0;
    while (!rsp_valid && k < int'(TO) + 10) begin
      @(negedge clk);
      k++;
    end
    chk("to/cycles",    32'(k),         32'(TO));
    chk("to/rsp_err",   32'(rsp_err),   32'd1);
    chk("to/rsp_rdata", rsp_rdata,      32'd0);
    // A stray response in IDLE is ignored
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1111_1111;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("stray/rsp_valid", 32'(rsp_valid), 32'd0);
    chk("stray/req_ready", 32'(req_ready), 32'd1);

    // Reset while waiting for a response
    req_valid = 1'b1; req_wen = 0; req_funct3 = 3'b010; req_addr = 32'h0000_00C0;
    @(negedge clk);
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstw/mem_addr",  mem_addr,       32'd0);
    chk("rstw/rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstw/rsp_rdata", rsp_rdata,      32'd0);
    chk("rstw/req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h2222_2222;
    seen_mv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      seen_mv |= rsp_valid;
    end
    chk("rstw/no_rsp", 32'(seen_mv), 32'd0);
    do_op("lw_after", 0, 3'b010, 32'h0000_00C4, 0, 0, 0, 32'h0BAD_F00D, 32'h0000_00C4, 0, 8'h00, 32'h0BAD_F00D);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
